// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg
//   Shared constants and types for the CPU output capture path.
//   DEFAULT_WIDTH : width of the CPU's CPUOut word.
//   STAMP_W       : width of the optional cycle timestamp.
//   STAMP_BITS    : extra bits each FIFO entry carries for the stamp (0 when the
//                   stamp is not built).
//   entry_t       : FIFO entry layout at the default data width.
//   Optional feature macro: CPUOUT_TIMESTAMP_EN adds a 16-bit stamp to every entry.
package cpu_io_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int STAMP_W       = 16;

`ifdef CPUOUT_TIMESTAMP_EN
  localparam int STAMP_BITS = STAMP_W;

  typedef struct packed {
    logic [STAMP_W-1:0]       stamp;
    logic [DEFAULT_WIDTH-1:0] data;
  } entry_t;
`else
  localparam int STAMP_BITS = 0;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
  } entry_t;
`endif

endpackage

// File: rtl/cpu_out_capture_sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is presented on
//   rdata whenever the FIFO is not empty. rdata reads as zero while the FIFO is
//   empty, so nothing stale leaks out after reset.
//   Parameters: entry_t (stored entry type), DEPTH (power of 2, at least 2).
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   synchronous active-high reset; clears pointers and occupancy
//     push   in   write wdata this edge (accepted if not full, or if a pop
//                 happens in the same edge)
//     pop    in   drop the head entry this edge (ignored while empty)
//     wdata  in   entry to write
//     rdata  out  head entry
//     count  out  occupancy 0..DEPTH
//     full   out  count == DEPTH
//     empty  out  count == 0
module sync_fifo #(
  parameter type entry_t = logic [31:0],
  parameter int  DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same edge frees a slot, so a full FIFO can still take a push.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of 2. Occupancy is tracked
  // separately, since equal pointers are ambiguous between empty and full.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; the empty-gated read keeps stale words invisible.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cpu_out_capture.sv
// cpu_out_capture
//   Watches the CPU's CPUOut word, queues every change in a small FIFO and hands
//   the queued words to a sink over a valid/ready handshake.
//   Parameters: WIDTH (data width, default 32), DEPTH (FIFO entries, power of 2).
//   Ports:
//     CLK       in   system clock, rising edge
//     Reset     in   synchronous active-high reset
//     CPUOut    in   word driven by the CPU
//     OutData   out  head-of-FIFO word, valid while OutValid=1
//     OutValid  out  FIFO not empty
//     OutReady  in   sink takes OutData this cycle
//     Full      out  FIFO holds DEPTH entries
//     Count     out  occupancy 0..DEPTH
//     Overflow  out  sticky: a change was dropped on a full FIFO
//     OutStamp  out  (CPUOUT_TIMESTAMP_EN only) cycle stamp of the head word
//   Optional feature macro: CPUOUT_TIMESTAMP_EN.
module cpu_out_capture
  import cpu_io_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [WIDTH-1:0]       CPUOut,
  output logic [WIDTH-1:0]       OutData,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic                   Full,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow
`ifdef CPUOUT_TIMESTAMP_EN
  ,
  output logic [STAMP_W-1:0]     OutStamp
`endif
);

  typedef struct packed {
`ifdef CPUOUT_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp;
`endif
    logic [WIDTH-1:0]   data;
  } cap_entry_t;

  logic [WIDTH-1:0] prev;
  logic             push_req;
  logic             fifo_empty;
  cap_entry_t       wr_entry;
  cap_entry_t       rd_entry;

  // The shadow copy also loads during reset, so a value already sitting on
  // CPUOut when reset releases is not mistaken for a fresh write.
  always_ff @(posedge CLK) begin
    prev <= CPUOut;
  end

  assign push_req      = (CPUOut != prev);
  assign wr_entry.data = CPUOut;
  assign OutData       = rd_entry.data;
  assign OutValid      = ~fifo_empty;

  // A change is lost only when the FIFO is full and no pop frees a slot.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      Overflow <= 1'b0;
    end else if (push_req && Full && !(OutValid && OutReady)) begin
      Overflow <= 1'b1;
    end
  end

`ifdef CPUOUT_TIMESTAMP_EN
  logic [STAMP_W-1:0] stamp_cnt;

  // Free-running cycle counter; each entry records its value at the push edge.
  always_ff @(posedge CLK) begin
    if (Reset) stamp_cnt <= '0;
    else       stamp_cnt <= stamp_cnt + 1'b1;
  end

  assign wr_entry.stamp = stamp_cnt;
  assign OutStamp       = rd_entry.stamp;
`endif

  sync_fifo #(
    .entry_t (cap_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .reset (Reset),
    .push  (push_req),
    .pop   (OutReady),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (Count),
    .full  (Full),
    .empty (fifo_empty)
  );

endmodule
